femto_spi_ram_responder: RTL and testbench

//  SPI-slave responder for the SPI SRAM link that the femto core drives as master
//  (spi_clk_ram/spi_cs_n_ram/spi_mosi_ram/spi_miso_ram). Decodes 23LC1024-style

---
 rtl/femto_spi_pkg.sv | 16 +
 rtl/femto_spi_sync_edge.sv | 27 ++
 rtl/femto_spi_ram_responder.sv | 174 +++++++++++++++++
 tb/tb_femto_spi_ram_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/femto_spi_pkg.sv
// Shared opcodes and FSM encoding for the SPI SRAM responder.
package femto_spi_pkg;

  localparam logic [7:0] SPI_OP_READ  = 8'h03;
  localparam logic [7:0] SPI_OP_WRITE = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    RD,
    WR,
    IGNORE
  } spi_state_t;

endpackage

// File: rtl/femto_spi_sync_edge.sv
// 2-FF synchroniser with single-cycle rise/fall pulses on the synchronised level.
module femto_spi_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [2:0] r_sync;

  // Resetting to 0 means a chip select already held low at reset release produces
  // no falling edge, so an in-flight frame is ignored.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= 3'b000;
    end else begin
      r_sync <= {r_sync[1:0], i_async};
    end
  end

  assign o_level = r_sync[1];
  assign o_rise  = r_sync[1] & ~r_sync[2];
  assign o_fall  = ~r_sync[1] & r_sync[2];

endmodule

// File: rtl/femto_spi_ram_responder.sv
// SPI mode-0 slave decoding 23LC1024-style sequential READ/WRITE onto a
// synchronous byte-wide memory port.
module femto_spi_ram_responder #(
  parameter int ADDR_BYTES = 3,
  parameter int MEM_AW     = 17
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata
);
  import femto_spi_pkg::*;

  localparam int ADDR_BITS = 8 * ADDR_BYTES;
  localparam int CNT_W     = $clog2(ADDR_BITS + 1);

  logic w_clk_rise, w_clk_fall, w_clk_lvl_unused;
  logic w_cs_rise, w_cs_fall, w_cs_lvl_unused;
  logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

  spi_state_t        r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [MEM_AW-2:0] r_rx;
  logic [MEM_AW-1:0] w_rx_next;
  logic [MEM_AW-1:0] r_addr;
  logic [7:0]        r_tx, r_wdata;
  logic              r_is_rd, r_mem_re, r_mem_we, r_rd_pend, r_miso;
  logic              w_cnt7, w_addr_last;

  femto_spi_sync_edge u_sync_clk (
    .clk(clk), .resetn(resetn), .i_async(spi_clk),
    .o_level(w_clk_lvl_unused), .o_rise(w_clk_rise), .o_fall(w_clk_fall)
  );

  femto_spi_sync_edge u_sync_cs (
    .clk(clk), .resetn(resetn), .i_async(spi_cs_n),
    .o_level(w_cs_lvl_unused), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  femto_spi_sync_edge u_sync_mosi (
    .clk(clk), .resetn(resetn), .i_async(spi_mosi),
    .o_level(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
  );

  // Only the low MEM_AW wire-address bits matter, so the high ones simply shift out.
  assign w_rx_next   = {r_rx, w_mosi};
  assign w_cnt7      = (r_cnt == CNT_W'(7));
  assign w_addr_last = (r_cnt == CNT_W'(ADDR_BITS - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_cs_rise) begin
      w_state_next = IDLE;
    end else if (w_cs_fall) begin
      w_state_next = CMD;
    end else if (w_clk_rise) begin
      case (r_state)
        CMD: begin
          if (w_cnt7) begin
            if (w_rx_next[7:0] == SPI_OP_READ || w_rx_next[7:0] == SPI_OP_WRITE) begin
              w_state_next = ADDR;
            end else begin
              w_state_next = IGNORE;
            end
          end
        end
        ADDR: begin
          if (w_addr_last) begin
            w_state_next = r_is_rd ? RD : WR;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt     <= '0;
      r_rx      <= '0;
      r_addr    <= '0;
      r_tx      <= 8'h00;
      r_wdata   <= 8'h00;
      r_is_rd   <= 1'b0;
      r_mem_re  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_rd_pend <= 1'b0;
      r_miso    <= 1'b0;
    end else begin
      r_mem_re  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_rd_pend <= r_mem_re;
      if (r_rd_pend) begin
        r_tx <= mem_rdata;
      end
      // The write address stays stable for the strobe cycle and advances afterwards.
      if (r_mem_we) begin
        r_addr <= r_addr + 1'b1;
      end
      if (w_cs_rise) begin
        r_cnt     <= '0;
        r_tx      <= 8'h00;
        r_rd_pend <= 1'b0;
      end else if (w_cs_fall) begin
        r_cnt <= '0;
        r_rx  <= '0;
      end else begin
        if (w_clk_rise) begin
          r_rx  <= w_rx_next[MEM_AW-2:0];
          r_cnt <= r_cnt + 1'b1;
          case (r_state)
            CMD: begin
              if (w_cnt7) begin
                r_cnt   <= '0;
                r_is_rd <= (w_rx_next[7:0] == SPI_OP_READ);
              end
            end
            ADDR: begin
              if (w_addr_last) begin
                r_cnt    <= '0;
                r_addr   <= w_rx_next;
                r_mem_re <= r_is_rd;
              end
            end
            RD: begin
              if (w_cnt7) begin
                r_cnt    <= '0;
                r_addr   <= r_addr + 1'b1;
                r_mem_re <= 1'b1;
              end
            end
            WR: begin
              if (w_cnt7) begin
                r_cnt    <= '0;
                r_mem_we <= 1'b1;
                r_wdata  <= w_rx_next[7:0];
              end
            end
            default: ;
          endcase
        end
        if (w_clk_fall && r_state == RD) begin
          r_miso <= r_tx[7];
          r_tx   <= {r_tx[6:0], 1'b0};
        end
      end
      if (w_state_next != RD) begin
        r_miso <= 1'b0;
      end
    end
  end

  assign spi_miso  = r_miso;
  assign mem_addr  = r_addr;
  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_femto_spi_ram_responder.sv
// Directed bench: SPI master tasks, behavioural 128 KiB memory, strobe logging.
module tb_femto_spi_ram_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        spi_clk, spi_cs_n, spi_mosi;
  logic        spi_miso;
  logic [16:0] mem_addr;
  logic        mem_re, mem_we;
  logic [7:0]  mem_rdata, mem_wdata;

  logic [7:0]  mem [0:131071];
  logic [16:0] re_q[$];
  logic [16:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int          errors = 0;
  int          checks = 0;
  int          overlap = 0;

  always #5 clk = ~clk;

  femto_spi_ram_responder dut (
    .clk(clk), .resetn(resetn),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  always @(posedge clk) begin
    if (mem_re) begin
      mem_rdata <= mem[mem_addr];
      re_q.push_back(mem_addr);
    end
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
    if (mem_re && mem_we) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] pop_re();
    if (re_q.size() > 0) return {15'd0, re_q.pop_front()};
    return 'x;
  endfunction

  function automatic logic [31:0] pop_wa();
    if (wa_q.size() > 0) return {15'd0, wa_q.pop_front()};
    return 'x;
  endfunction

  function automatic logic [31:0] pop_wd();
    if (wd_q.size() > 0) return {24'd0, wd_q.pop_front()};
    return 'x;
  endfunction

  task automatic clear_q();
    re_q.delete();
    wa_q.delete();
    wd_q.delete();
  endtask

  // Mode 0: mosi changes with the falling edge, miso is sampled just before the rise.
  task automatic spi_bit(input logic b, output logic r);
    spi_mosi = b;
    wait_clks(4);
    r = spi_miso;
    spi_clk = 1'b1;
    wait_clks(4);
    spi_clk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], b);
      rx[i] = b;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_clks(8);
  endtask

  task automatic cs_high();
    spi_mosi = 1'b0;
    spi_cs_n = 1'b1;
    wait_clks(8);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a, output logic [7:0] or_rx);
    logic [7:0] r;
    or_rx = 8'h00;
    spi_byte(op, r);        or_rx |= r;
    spi_byte(a[23:16], r);  or_rx |= r;
    spi_byte(a[15:8], r);   or_rx |= r;
    spi_byte(a[7:0], r);    or_rx |= r;
  endtask

  initial begin
    logic [7:0] rx, hdr_or, acc;
    logic       b;
    logic [2:0] bits;

    for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
    resetn   = 1'b0;
    spi_clk  = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    wait_clks(5);
    chk("rst_miso", {31'd0, spi_miso}, 0);
    chk("rst_re", {31'd0, mem_re}, 0);
    chk("rst_we", {31'd0, mem_we}, 0);
    chk("rst_addr", {15'd0, mem_addr}, 0);
    chk("rst_wdata", {24'd0, mem_wdata}, 0);
    resetn = 1'b1;
    wait_clks(8);

    // WRITE two bytes at 0x10
    clear_q();
    cs_low();
    send_hdr(8'h02, 24'h000010, hdr_or);
    spi_byte(8'hA5, rx);
    spi_byte(8'h5A, rx);
    cs_high();
    chk("wr_count", wa_q.size(), 2);
    chk("wr0_addr", pop_wa(), 32'h10);
    chk("wr0_data", pop_wd(), 32'hA5);
    chk("wr1_addr", pop_wa(), 32'h11);
    chk("wr1_data", pop_wd(), 32'h5A);
    chk("wr_no_re", re_q.size(), 0);

    // READ two bytes from 0x10 with prefetch of 0x12
    mem[16] = 8'hA5;
    mem[17] = 8'h5A;
    mem[18] = 8'h3C;
    clear_q();
    cs_low();
    send_hdr(8'h03, 24'h000010, hdr_or);
    chk("rd_hdr_miso", {24'd0, hdr_or}, 0);
    spi_byte(8'h00, rx);
    chk("rd_byte0", {24'd0, rx}, 32'hA5);
    spi_byte(8'h00, rx);
    chk("rd_byte1", {24'd0, rx}, 32'h5A);
    cs_high();
    chk("rd_re_count", re_q.size(), 3);
    chk("rd_re0", pop_re(), 32'h10);
    chk("rd_re1", pop_re(), 32'h11);
    chk("rd_re2", pop_re(), 32'h12);
    chk("rd_no_we", wa_q.size(), 0);
    chk("rd_idle_miso", {31'd0, spi_miso}, 0);

    // WRITE across the top of the address space
    clear_q();
    cs_low();
    send_hdr(8'h02, 24'h01FFFF, hdr_or);
    spi_byte(8'h11, rx);
    spi_byte(8'h22, rx);
    cs_high();
    chk("wrap_count", wa_q.size(), 2);
    chk("wrap0_addr", pop_wa(), 32'h1FFFF);
    chk("wrap0_data", pop_wd(), 32'h11);
    chk("wrap1_addr", pop_wa(), 32'h00000);
    chk("wrap1_data", pop_wd(), 32'h22);
    chk("wrap_mem_top", {24'd0, mem[131071]}, 32'h11);
    chk("wrap_mem_zero", {24'd0, mem[0]}, 32'h22);

    // Partial write byte is discarded
    mem[32] = 8'h77;
    clear_q();
    cs_low();
    send_hdr(8'h02, 24'h000020, hdr_or);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
    cs_high();
    chk("partial_no_we", wa_q.size(), 0);
    cs_low();
    send_hdr(8'h03, 24'h000020, hdr_or);
    spi_byte(8'h00, rx);
    cs_high();
    chk("partial_readback", {24'd0, rx}, 32'h77);

    // Unknown opcode is ignored
    clear_q();
    cs_low();
    spi_byte(8'h9F, rx);
    acc = rx;
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'hFF, rx);
      acc |= rx;
    end
    cs_high();
    chk("ign_miso", {24'd0, acc}, 0);
    chk("ign_no_re", re_q.size(), 0);
    chk("ign_no_we", wa_q.size(), 0);
    cs_low();
    send_hdr(8'h03, 24'h000010, hdr_or);
    spi_byte(8'h00, rx);
    cs_high();
    chk("ign_then_read", {24'd0, rx}, 32'hA5);

    // Reset in the middle of a READ data byte (0x11 = 5A)
    cs_low();
    send_hdr(8'h03, 24'h000011, hdr_or);
    for (int i = 2; i >= 0; i--) begin
      spi_bit(1'b0, b);
      bits[i] = b;
    end
    chk("mid_bits", {29'd0, bits}, 32'h2);
    wait_clks(4);
    chk("mid_miso_bit4", {31'd0, spi_miso}, 1);
    resetn = 1'b0;
    #1;
    chk("arst_miso", {31'd0, spi_miso}, 0);
    chk("arst_re", {31'd0, mem_re}, 0);
    chk("arst_we", {31'd0, mem_we}, 0);
    wait_clks(4);
    clear_q();
    resetn = 1'b1;
    wait_clks(4);
    acc = 8'h00;
    for (int i = 0; i < 13; i++) begin
      spi_bit(1'b1, b);
      acc[0] = acc[0] | b;
    end
    cs_high();
    chk("inflight_miso", {24'd0, acc}, 0);
    chk("inflight_no_re", re_q.size(), 0);
    chk("inflight_no_we", wa_q.size(), 0);
    cs_low();
    send_hdr(8'h03, 24'h01FFFF, hdr_or);
    spi_byte(8'h00, rx);
    chk("post_rst_byte0", {24'd0, rx}, 32'h11);
    spi_byte(8'h00, rx);
    chk("post_rst_byte1", {24'd0, rx}, 32'h22);
    cs_high();
    chk("post_rst_re0", pop_re(), 32'h1FFFF);
    chk("post_rst_re1", pop_re(), 32'h00000);
    chk("post_rst_re2", pop_re(), 32'h00001);

    chk("re_we_overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
